// File: rtl/gelato_fetch_scheduler.sv
// Round-robin warp fetch scheduler: picks one ready warp per cycle and issues its PC to i-fetch.
// Optional perf counters enabled by defining GELATO_FETCH_SKD_PERF_CNT_EN.
module gelato_fetch_scheduler #(
  parameter int WARP_NUM        = 4,
  parameter int PC_WIDTH        = 32,
  parameter int SPLIT_NUM_WIDTH = 3,
  parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rdy,
  input  logic [WARP_NUM-1:0]                 pc_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0]        pc,
  input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pc_split_num,
  input  logic                                activate_valid,
  input  logic [WARP_NUM_WIDTH-1:0]           activate_warp_num,
  output logic                                fetch_valid,
  input  logic                                fetch_ready,
  output logic [PC_WIDTH-1:0]                 fetch_pc,
  output logic [WARP_NUM_WIDTH-1:0]           fetch_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
  output logic [WARP_NUM-1:0]                 busy,
  output logic                                activate_err
`ifdef GELATO_FETCH_SKD_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_issue_cnt,
  output logic [31:0]                         perf_stall_cnt,
  output logic [31:0]                         perf_idle_cnt
`endif
);

  logic                       fetch_valid_q;
  logic [PC_WIDTH-1:0]        fetch_pc_q;
  logic [WARP_NUM_WIDTH-1:0]  fetch_warp_q;
  logic [SPLIT_NUM_WIDTH-1:0] fetch_split_q;
  logic [WARP_NUM-1:0]        busy_q, busy_d;
  logic [WARP_NUM_WIDTH-1:0]  ptr_q, ptr_d;
  logic                       err_q, err_d;

  logic [WARP_NUM-1:0]        eligible;
  logic                       load;
  logic                       win_found;
  logic [WARP_NUM_WIDTH-1:0]  win;
  logic                       act_in_range;

  assign eligible     = pc_valid & ~busy_q;
  assign load         = !fetch_valid_q || fetch_ready;
  assign act_in_range = int'(activate_warp_num) < WARP_NUM;

  // First eligible warp scanning ptr, ptr+1, ... modulo WARP_NUM.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < WARP_NUM; k++) begin
      if (!win_found && eligible[(int'(ptr_q) + k) % WARP_NUM]) begin
        win_found = 1'b1;
        win       = WARP_NUM_WIDTH'((int'(ptr_q) + k) % WARP_NUM);
      end
    end
  end

  assign ptr_d = (int'(win) == WARP_NUM - 1) ? '0 : win + 1'b1;

  // Grant is applied after activate so a same-warp set/clear resolves to set.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (activate_valid) begin
      if (act_in_range && busy_q[activate_warp_num]) busy_d[activate_warp_num] = 1'b0;
      else                                           err_d = 1'b1;
    end
    if (load && win_found) busy_d[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_warp_q  <= '0;
      fetch_split_q <= '0;
      busy_q        <= '0;
      ptr_q         <= '0;
      err_q         <= 1'b0;
    end else if (rdy) begin
      busy_q <= busy_d;
      err_q  <= err_d;
      if (load) begin
        fetch_valid_q <= win_found;
        if (win_found) begin
          fetch_pc_q    <= pc[win*PC_WIDTH +: PC_WIDTH];
          fetch_warp_q  <= win;
          fetch_split_q <= pc_split_num[win*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
          ptr_q         <= ptr_d;
        end
      end
    end
  end

  assign fetch_valid     = fetch_valid_q;
  assign fetch_pc        = fetch_pc_q;
  assign fetch_warp_num  = fetch_warp_q;
  assign fetch_split_num = fetch_split_q;
  assign busy            = busy_q;
  assign activate_err    = err_q;

`ifdef GELATO_FETCH_SKD_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q, idle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else if (rdy) begin
      if (fetch_valid_q && fetch_ready)  issue_cnt_q <= issue_cnt_q + 32'd1;
      if (fetch_valid_q && !fetch_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!fetch_valid_q && !(|eligible)) idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_idle_cnt  = idle_cnt_q;
`endif

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Bench for gelato_fetch_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_gelato_fetch_scheduler;
  localparam int WN = 4;
  localparam int PW = 32;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rdy;
  logic [WN-1:0]  pc_valid;
  logic [WN*PW-1:0] pc;
  logic [WN*SW-1:0] pc_split_num;
  logic           activate_valid;
  logic [1:0]     activate_warp_num;
  logic           fetch_valid;
  logic           fetch_ready;
  logic [PW-1:0]  fetch_pc;
  logic [1:0]     fetch_warp_num;
  logic [SW-1:0]  fetch_split_num;
  logic [WN-1:0]  busy;
  logic           activate_err;
`ifdef GELATO_FETCH_SKD_PERF_CNT_EN
  logic [31:0]    perf_issue_cnt, perf_stall_cnt, perf_idle_cnt;
`endif

  gelato_fetch_scheduler #(.WARP_NUM(WN), .PC_WIDTH(PW), .SPLIT_NUM_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pc_valid(pc_valid), .pc(pc), .pc_split_num(pc_split_num),
    .activate_valid(activate_valid), .activate_warp_num(activate_warp_num),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_warp_num(fetch_warp_num), .fetch_split_num(fetch_split_num),
    .busy(busy), .activate_err(activate_err)
`ifdef GELATO_FETCH_SKD_PERF_CNT_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_idle_cnt(perf_idle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: set of in-flight warps, a round-robin start point and one output slot.
  bit          m_fv;
  bit [PW-1:0] m_pc;
  int          m_warp;
  int          m_split;
  bit          m_busy [WN];
  int          m_ptr;
  bit          m_err;

  task automatic mdl_reset();
    m_fv = 0; m_pc = '0; m_warp = 0; m_split = 0; m_ptr = 0; m_err = 0;
    for (int i = 0; i < WN; i++) m_busy[i] = 0;
  endtask

  task automatic mdl_edge();
    bit nb [WN];
    bit found;
    int w;
    if (!rdy) return;
    nb = m_busy;
    if (activate_valid) begin
      if (m_busy[int'(activate_warp_num)]) nb[int'(activate_warp_num)] = 0;
      else m_err = 1;
    end
    if (!m_fv || fetch_ready) begin
      found = 0;
      for (int k = 0; k < WN; k++) begin
        w = (m_ptr + k) % WN;
        if (!found && pc_valid[w] && !m_busy[w]) begin
          found   = 1;
          m_pc    = pc[w*PW +: PW];
          m_warp  = w;
          m_split = int'(pc_split_num[w*SW +: SW]);
          nb[w]   = 1;
          m_ptr   = (w + 1) % WN;
        end
      end
      m_fv = found;
    end
    m_busy = nb;
  endtask

  function automatic logic [WN-1:0] m_busy_vec();
    logic [WN-1:0] v;
    for (int i = 0; i < WN; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic cmp_all();
    chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
    if (m_fv) begin
      chk("fetch_pc", 64'(fetch_pc), 64'(m_pc));
      chk("fetch_warp", 64'(fetch_warp_num), 64'(m_warp));
      chk("fetch_split", 64'(fetch_split_num), 64'(m_split));
    end
    chk("busy", 64'(busy), 64'(m_busy_vec()));
    chk("activate_err", 64'(activate_err), 64'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_edge();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_all();
  endtask

  int prev;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; pc_valid = '0; activate_valid = 1'b0;
    activate_warp_num = '0; fetch_ready = 1'b1;
    for (int i = 0; i < WN; i++) begin
      pc[i*PW +: PW]           = 32'h1000 + 32'(i) * 32'h10;
      pc_split_num[i*SW +: SW] = SW'(i + 1);
    end
    mdl_reset();
    do_reset();

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rst_fv", 64'(fetch_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(activate_err), 64'd0);
    end

    // All valid: warps 0..3 on consecutive cycles
    pc_valid = 4'hF;
    for (int i = 0; i < WN; i++) begin
      tick();
      chk("issue_order", 64'(fetch_warp_num), 64'(i));
      chk("issue_pc", 64'(fetch_pc), 64'h1000 + 64'(i) * 64'h10);
    end
    tick();
    chk("all_busy_fv", 64'(fetch_valid), 64'd0);
    chk("all_busy", 64'(busy), 64'hF);

    // Re-activate warp 2 with a new PC
    pc[2*PW +: PW] = 32'h2222;
    activate_valid = 1'b1; activate_warp_num = 2'd2;
    tick();
    chk("act_clear", 64'(busy), 64'hB);
    chk("act_fv", 64'(fetch_valid), 64'd0);
    activate_valid = 1'b0;
    tick();
    chk("reissue_fv", 64'(fetch_valid), 64'd1);
    chk("reissue_warp", 64'(fetch_warp_num), 64'd2);
    chk("reissue_pc", 64'(fetch_pc), 64'h2222);
    chk("reissue_busy", 64'(busy), 64'hF);

    // Stall: warp 1 held while its PC changes
    pc[1*PW +: PW] = 32'h100;
    activate_valid = 1'b1; activate_warp_num = 2'd1;
    tick();
    activate_valid = 1'b0; fetch_ready = 1'b0;
    tick();
    chk("stall_warp", 64'(fetch_warp_num), 64'd1);
    pc[1*PW +: PW] = 32'h200;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_fv", 64'(fetch_valid), 64'd1);
      chk("stall_pc", 64'(fetch_pc), 64'h100);
    end
    fetch_ready = 1'b1;
    tick();
    chk("accept_fv", 64'(fetch_valid), 64'd0);

    // Strict round-robin with continuous re-activation
    do_reset();
    pc_valid = 4'hF;
    prev = -1;
    for (int c = 0; c < 16; c++) begin
      activate_valid = m_fv;
      activate_warp_num = 2'(m_warp);
      tick();
      chk("rr_fv", 64'(fetch_valid), 64'd1);
      if (prev >= 0) chk("rr_order", 64'(fetch_warp_num), 64'((prev + 1) % WN));
      prev = int'(fetch_warp_num);
    end
    activate_valid = 1'b0;

    // Activate of an idle warp, then freeze with rdy=0
    do_reset();
    pc_valid = 4'h0;
    activate_valid = 1'b1; activate_warp_num = 2'd3;
    tick();
    chk("bad_act_err", 64'(activate_err), 64'd1);
    chk("bad_act_busy", 64'(busy), 64'd0);
    activate_valid = 1'b0;
    tick();
    chk("err_sticky", 64'(activate_err), 64'd1);
    pc_valid = 4'hF; fetch_ready = 1'b0;
    tick();
    rdy = 1'b0; fetch_ready = 1'b1; pc_valid = 4'h6;
    activate_valid = 1'b1; activate_warp_num = 2'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("frz_fv", 64'(fetch_valid), 64'd1);
      chk("frz_warp", 64'(fetch_warp_num), 64'd0);
      chk("frz_busy", 64'(busy), 64'h1);
    end
    rdy = 1'b1; activate_valid = 1'b0;

    // Asynchronous reset while a request is outstanding
    #2 rst_n = 1'b0;
    #1;
    chk("async_fv", 64'(fetch_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    mdl_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(9) != 0);
      if ($urandom_range(3) == 0) pc_valid = WN'($urandom);
      fetch_ready = ($urandom_range(9) < 7);
      if ($urandom_range(4) == 0) begin
        int w = int'($urandom_range(WN - 1));
        pc[w*PW +: PW] = $urandom;
        pc_split_num[w*SW +: SW] = SW'($urandom);
      end
      activate_valid = 1'b0;
      if ($urandom_range(9) < 6) begin
        int w = int'($urandom_range(WN - 1));
        for (int k = 0; k < WN; k++)
          if (!m_busy[w] && m_busy[(w + k) % WN]) w = (w + k) % WN;
        if (m_busy[w] || $urandom_range(19) == 0) begin
          activate_valid = 1'b1;
          activate_warp_num = 2'(w);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
